prog_loader: RTL

//  Byte-stream program loader: the writer for the instruction memory that fetch reads.

---
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream loader bus: byte input handshake, imem write port, status.
// master = stream source / supervisor, slave = loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              iSTART;
  logic              iBYTE_VALID;
  logic [7:0]        iBYTE;
  logic              oBYTE_READY;
  logic              oMEM_WE;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [DATA_W-1:0] oMEM_DATA;
  logic [ADDR_W:0]   oWORD_COUNT;
  logic              oCPU_HOLD;
  logic              oBUSY;
  logic              oDONE;
  logic              oERROR;

  modport master (
    output iSTART, iBYTE_VALID, iBYTE,
    input  oBYTE_READY, oMEM_WE, oMEM_ADDR,
    input  oMEM_DATA, oWORD_COUNT, oCPU_HOLD,
    input  oBUSY, oDONE, oERROR
  );

  modport slave (
    input  iSTART, iBYTE_VALID, iBYTE,
    output oBYTE_READY, oMEM_WE, oMEM_ADDR,
    output oMEM_DATA, oWORD_COUNT, oCPU_HOLD,
    output oBUSY, oDONE, oERROR
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds CPU until done.
// Optional trailing XOR checksum: define PROG_LOADER_CSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic         iCLK,
  input logic         iRST,
  prog_loader_if.slave bus
);

  localparam int CW = ADDR_W + 1;

`ifdef PROG_LOADER_CSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN, S_HI, S_LO,
    S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN, S_HI, S_LO,
    S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  state_t            state;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              ready;
  logic              xfer;
  logic [CW-1:0]     count_nx;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    ready = 1'b0;
    unique case (state)
      S_SYNC, S_LEN,
      S_HI, S_LO:  ready = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM:      ready = 1'b1;
`endif
      default:     ready = 1'b0;
    endcase
  end

  assign xfer     = ready & bus.iBYTE_VALID;
  assign count_nx = count + 1'b1;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= S_IDLE;
      hi       <= '0;
      addr     <= '0;
      count    <= '0;
      n        <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
`ifdef PROG_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (bus.iSTART) begin
        state <= S_SYNC;
      end else begin
        unique case (state)
          S_SYNC: begin
            if (xfer && bus.iBYTE == 8'hA5)
              state <= S_LEN;
          end
          S_LEN: begin
            if (xfer) begin
              // a length byte of 0 means a full 256-word image
              n     <= (bus.iBYTE == 8'h00) ?
                       CW'(256) : CW'(bus.iBYTE);
              addr  <= '0;
              count <= '0;
`ifdef PROG_LOADER_CSUM_EN
              csum  <= '0;
`endif
              state <= S_HI;
            end
          end
          S_HI: begin
            if (xfer) begin
              hi    <= bus.iBYTE;
`ifdef PROG_LOADER_CSUM_EN
              csum  <= csum ^ bus.iBYTE;
`endif
              state <= S_LO;
            end
          end
          S_LO: begin
            if (xfer) begin
              mem_we   <= 1'b1;
              mem_addr <= addr;
              mem_data <= {hi, bus.iBYTE};
`ifdef PROG_LOADER_CSUM_EN
              csum     <= csum ^ bus.iBYTE;
`endif
              state    <= S_WRITE;
            end
          end
          S_WRITE: begin
            addr  <= addr + 1'b1;
            count <= count_nx;
            if (count_nx == n)
`ifdef PROG_LOADER_CSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            else
              state <= S_HI;
          end
`ifdef PROG_LOADER_CSUM_EN
          S_CSUM: begin
            if (xfer)
              state <= (bus.iBYTE == csum) ?
                       S_DONE : S_ERR;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.oBYTE_READY = ready;
  assign bus.oMEM_WE     = mem_we;
  assign bus.oMEM_ADDR   = mem_addr;
  assign bus.oMEM_DATA   = mem_data;
  assign bus.oWORD_COUNT = count;
  assign bus.oCPU_HOLD   = (state != S_DONE);
  assign bus.oDONE       = (state == S_DONE);
  assign bus.oBUSY       = !(state inside {S_IDLE, S_DONE, S_ERR});
`ifdef PROG_LOADER_CSUM_EN
  assign bus.oERROR      = (state == S_ERR);
`else
  assign bus.oERROR      = 1'b0;
`endif

endmodule
